// File: rtl/divider_8bit_seq_pkg.sv
// divider_8bit_seq shared package
// State encoding and fixed widths for the sequential divider.
package divider_8bit_seq_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_8bit_seq_subtractor.sv
// 9-bit ripple subtractor built from full-adder cells
// diff = a - b; borrow set when b > a.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module subtractor_9bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);

  logic [9:0] c;

  // two's-complement: a + ~b + 1
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 9; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[9];

endmodule

// File: rtl/divider_8bit_seq.sv
// Sequential unsigned 8-bit restoring divider
// start/busy/done handshake, one quotient bit per CALC cycle.
module divider_8bit_seq
  import divider_8bit_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  state_t state, state_nx;

  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] r_r;
  logic [2:0]        cnt;

  logic [8:0]        t_a;
  logic [8:0]        t;
  logic              borrow;
  logic              keep;
  logic [DATA_W-1:0] r_nx;
  logic [DATA_W-1:0] q_nx;
  logic              accept;

  assign accept = (state == IDLE) && start;

  assign t_a = {r_r, q_r[DATA_W-1]};

  subtractor_9bit u_sub (
    .a      (t_a),
    .b      ({1'b0, d_r}),
    .diff   (t),
    .borrow (borrow)
  );

  // R < D keeps T below D, so T[8] is zero whenever there is no borrow
  assign keep = ~borrow & ~t[8];
  assign r_nx = keep ? t[DATA_W-1:0] : t_a[DATA_W-1:0];
  assign q_nx = {q_r[DATA_W-2:0], keep};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          state_nx = (divisor == '0) ? DONE : CALC;
        end
      end
      (state == CALC): begin
        if (cnt == 3'd7) begin
          state_nx = DONE;
        end
      end
      (state == DONE): state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_r <= dividend;
      d_r <= divisor;
      r_r <= '0;
      cnt <= '0;
      if (divisor == '0) begin
        quotient    <= DIV0_QUOTIENT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      q_r <= q_nx;
      r_r <= r_nx;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        quotient    <= q_nx;
        remainder   <= r_nx;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Directed and random checks for divider_8bit_seq
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_divider_8bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int nvec;
  int nerr;

  logic [7:0] pq;
  logic [7:0] pr;
  logic       pz;

  divider_8bit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    #3;
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      nerr++;
      $display("FAIL reset_outputs got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      nerr++;
      $display("FAIL reset_idle got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    pq = 8'd0;
    pr = 8'd0;
    pz = 1'b0;
  endtask

  // Issue one request in IDLE and follow it cycle by cycle to done.
  task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ez, input string nm);
    int lat;
    lat      = ez ? 1 : 9;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h00;
    for (int i = 1; i <= lat; i++) begin
      nvec++;
      if (busy !== (i < lat) || done !== (i == lat)) begin
        nerr++;
        $display("FAIL %s_hs cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                 nm, i, busy, done, i < lat, i == lat);
      end
      if (i < lat) begin
        if (quotient !== pq || remainder !== pr || div_by_zero !== pz) begin
          nerr++;
          $display("FAIL %s_hold cyc=%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   nm, i, quotient, remainder, div_by_zero, pq, pr, pz);
        end
      end else begin
        if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
          nerr++;
          $display("FAIL %s_result got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   nm, quotient, remainder, div_by_zero, eq, er, ez);
        end
      end
      tick();
    end
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL %s_idle got busy=%b done=%b want 0 0", nm, busy, done);
    end
    pq = eq;
    pr = er;
    pz = ez;
  endtask

  task automatic test_basic();
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "div_200_7");
  endtask

  task automatic test_edges();
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "div_255_1");
    run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "div_5_9");
    run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "div_0_3");
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "div_255_255");
  endtask

  task automatic test_div_by_zero();
    run_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, "div_77_0");
    run_div(8'd13, 8'd2, 8'd6, 8'd1, 1'b0, "after_div0");
  endtask

  // start re-pulsed during CALC with other operands must be ignored
  task automatic test_start_ignored();
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd10;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      nvec++;
      if (busy !== (i < 9) || done !== (i == 9)) begin
        nerr++;
        $display("FAIL ignore_hs cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                 i, busy, done, i < 9, i == 9);
      end
      if (i == 9) begin
        if (quotient !== 8'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
          nerr++;
          $display("FAIL ignore_result got q=%0d r=%0d z=%b want q=10 r=0 z=0",
                   quotient, remainder, div_by_zero);
        end
      end
      start    = (i == 2) || (i == 5);
      dividend = (i == 2) ? 8'd50 : 8'd9;
      divisor  = (i == 2) ? 8'd3 : 8'd2;
      tick();
    end
    start = 1'b0;
    pq = 8'd10;
    pr = 8'd0;
    pz = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_div(8'd99, 8'd8, 8'd12, 8'd3, 1'b0, "b2b_99_8");
    run_div(8'd250, 8'd16, 8'd15, 8'd10, 1'b0, "b2b_250_16");
  endtask

  task automatic test_reset_mid();
    start    = 1'b1;
    dividend = 8'd123;
    divisor  = 8'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      nerr++;
      $display("FAIL midreset_async got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL midreset_nodone got busy=%b done=%b want 0 0", busy, done);
      end
      if (i == 2) rst_n = 1'b1;
    end
    pq = 8'd0;
    pr = 8'd0;
    pz = 1'b0;
    run_div(8'd123, 8'd4, 8'd30, 8'd3, 1'b0, "after_reset_123_4");
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = (n % 64 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0)
        run_div(a, b, 8'hFF, a, 1'b1, "rand");
      else
        run_div(a, b, a / b, a % b, 1'b0, "rand");
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
